// File: rtl/branch_conditional_unit_if.sv
// Purpose: decode-side and resolution-side signal bundle for branch_conditional_unit.
// Latency: none. This is wiring only.
// Backpressure: stall_o tells the decode stage to hold, and overflow_o records any entry dropped while full.
//
// Ports carried (master = decode/retire side, slave = branch unit):
//   decode -> unit : enable_i, opcode_i, functionalUnitType_i, instructionAddress_i,
//                    instMajId_i, is64Bit_i, instructionBody_i, cr_i, flush_i,
//                    ctrLoad_i, ctrLoadValue_i
//   unit -> decode : stall_o, overflow_o, resolveValid_o, resolveMajId_o, taken_o,
//                    target_o, lrWrite_o, ctr_o, lr_o
// instructionBody_i uses big-endian bit numbering ([0] is the MSB) to match the ISA fields.
interface branch_conditional_unit_if #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int bodyWidth               = 28
);
    logic                               enable_i;
    logic [opcodeSize-1:0]              opcode_i;
    logic [funcUnitCodeSize-1:0]        functionalUnitType_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic [instructionCounterWidth-1:0] instMajId_i;
    logic                               is64Bit_i;
    logic [0:bodyWidth-1]               instructionBody_i;
    logic [31:0]                        cr_i;
    logic                               flush_i;
    logic                               ctrLoad_i;
    logic [addressWidth-1:0]            ctrLoadValue_i;

    logic                               stall_o;
    logic                               overflow_o;
    logic                               resolveValid_o;
    logic [instructionCounterWidth-1:0] resolveMajId_o;
    logic                               taken_o;
    logic [addressWidth-1:0]            target_o;
    logic                               lrWrite_o;
    logic [addressWidth-1:0]            ctr_o;
    logic [addressWidth-1:0]            lr_o;

    modport master (
        output enable_i, opcode_i, functionalUnitType_i, instructionAddress_i, instMajId_i,
               is64Bit_i, instructionBody_i, cr_i, flush_i, ctrLoad_i, ctrLoadValue_i,
        input  stall_o, overflow_o, resolveValid_o, resolveMajId_o, taken_o, target_o,
               lrWrite_o, ctr_o, lr_o
    );

    modport slave (
        input  enable_i, opcode_i, functionalUnitType_i, instructionAddress_i, instMajId_i,
               is64Bit_i, instructionBody_i, cr_i, flush_i, ctrLoad_i, ctrLoadValue_i,
        output stall_o, overflow_o, resolveValid_o, resolveMajId_o, taken_o, target_o,
               lrWrite_o, ctr_o, lr_o
    );
endinterface

// File: rtl/branch_conditional_unit.sv
// Purpose: queue B-form conditional branches, resolve them against CR/CTR, and emit taken/target/LR records.
// Latency: an enqueue at edge N into an empty queue resolves at edge N+2. Throughput is one branch per 2 cycles.
// Backpressure: stall_o is asserted while the queue is full. An accepted entry that cannot be stored is dropped and sets sticky overflow_o.
//
// Ports: clock_i, reset_i (synchronous, active-high), bus (branch_conditional_unit_if.slave).
module branch_conditional_unit #(
    parameter int addressWidth            = 64,
    parameter int instructionCounterWidth = 64,
    parameter int opcodeSize              = 12,
    parameter int funcUnitCodeSize        = 3,
    parameter int BranchUnitID            = 6,
    parameter int bodyWidth               = 28,
    parameter int queueDepth              = 4
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    branch_conditional_unit_if.slave  bus
);
    localparam int PtrW  = $clog2(queueDepth);
    localparam int CntW  = PtrW + 1;
    localparam int HalfW = addressWidth / 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_EXEC = 1'b1;

    typedef struct packed {
        logic [instructionCounterWidth-1:0] id;
        logic [addressWidth-1:0]            addr;
        logic                               is64;
        logic [0:bodyWidth-1]               body;
    } branch_t;

    branch_t                 queue_q [queueDepth];
    branch_t                 in_br;
    branch_t                 work_q;
    logic [PtrW-1:0]         rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]         count_q;
    logic [0:0]              state_q;
    logic                    overflow_q, resolve_vld_q, taken_q, lr_wr_q;
    logic [instructionCounterWidth-1:0] maj_id_q;
    logic [addressWidth-1:0] target_q, ctr_q, lr_q;

    // In 32-bit mode the upper half of any produced address is forced to zero.
    function automatic logic [addressWidth-1:0] mode_mask(input logic [addressWidth-1:0] a,
                                                          input logic is64);
        mode_mask = is64 ? a : {{(addressWidth-HalfW){1'b0}}, a[HalfW-1:0]};
    endfunction

    // ---------------- enqueue / dequeue control ----------------
    logic accept, full, pop, push, ovf_set;

    assign accept  = bus.enable_i
                  && (bus.functionalUnitType_i == funcUnitCodeSize'(BranchUnitID))
                  && (bus.opcode_i == opcodeSize'(25));
    assign full    = (count_q == CntW'(queueDepth));
    assign pop     = (state_q == S_IDLE) && (count_q != '0) && !bus.flush_i;
    // A full queue still takes a new entry when the head leaves in the same cycle.
    assign push    = accept && !bus.flush_i && (!full || pop);
    assign ovf_set = accept && !bus.flush_i && full && !pop;

    always_comb begin
        in_br      = '0;
        in_br.id   = bus.instMajId_i;
        in_br.addr = bus.instructionAddress_i;
        in_br.is64 = bus.is64Bit_i;
        in_br.body = bus.instructionBody_i;
    end

    // ---------------- resolution of the working register ----------------
    logic [0:3]              bo;
    logic [4:0]              bi;
    logic                    aa, lk;
    logic [addressWidth-1:0] ctr_m, exts, tgt, nia;
    logic                    ctr_nz, ctr_ok, cond_ok, taken;
    logic                    unused_bo4;

    assign bo         = work_q.body[0:3];
    assign unused_bo4 = work_q.body[4];     // branch-prediction hint, no effect here
    assign bi         = work_q.body[5:9];
    assign aa         = work_q.body[26];
    assign lk         = work_q.body[27];

    assign ctr_m   = bo[2] ? ctr_q : ctr_q - addressWidth'(1);
    assign ctr_nz  = work_q.is64 ? (|ctr_m) : (|ctr_m[31:0]);
    assign ctr_ok  = bo[2] | (ctr_nz ^ bo[3]);
    assign cond_ok = bo[0] | (bus.cr_i[bi] == bo[1]);
    assign taken   = ctr_ok & cond_ok;

    // body[10:25] is BD||00, so this is the word displacement already scaled.
    assign exts = {{(addressWidth-16){work_q.body[10]}}, work_q.body[10:25]};
    assign tgt  = mode_mask(aa ? exts : work_q.addr + exts, work_q.is64);
    assign nia  = mode_mask(work_q.addr + addressWidth'(4), work_q.is64);

    // ---------------- storage ----------------
    always_ff @(posedge clock_i) begin
        if (push) begin
            queue_q[wr_ptr_q] <= in_br;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            work_q        <= '0;
            overflow_q    <= 1'b0;
            resolve_vld_q <= 1'b0;
            maj_id_q      <= '0;
            taken_q       <= 1'b0;
            target_q      <= '0;
            lr_wr_q       <= 1'b0;
            ctr_q         <= '0;
            lr_q          <= '0;
        end else begin
            resolve_vld_q <= 1'b0;
            if (bus.flush_i) begin
                // The branch in EXEC is killed, so no record is produced and CTR/LR keep their values.
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
                state_q  <= S_IDLE;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    work_q   <= queue_q[rd_ptr_q];
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    state_q  <= S_EXEC;
                end
                count_q <= count_q + CntW'(push) - CntW'(pop);
                if (state_q == S_EXEC) begin
                    state_q       <= S_IDLE;
                    resolve_vld_q <= 1'b1;
                    maj_id_q      <= work_q.id;
                    taken_q       <= taken;
                    target_q      <= taken ? tgt : nia;
                    lr_wr_q       <= lk;
                    if (!bo[2]) begin
                        ctr_q <= ctr_m;
                    end
                    if (lk) begin
                        lr_q <= nia;
                    end
                end
            end
            if (ovf_set) begin
                overflow_q <= 1'b1;
            end
            // An mtctr write wins over a decrement in the same cycle.
            if (bus.ctrLoad_i) begin
                ctr_q <= bus.ctrLoadValue_i;
            end
        end
    end

    assign bus.stall_o        = full;
    assign bus.overflow_o     = overflow_q;
    assign bus.resolveValid_o = resolve_vld_q;
    assign bus.resolveMajId_o = maj_id_q;
    assign bus.taken_o        = taken_q;
    assign bus.target_o       = target_q;
    assign bus.lrWrite_o      = lr_wr_q;
    assign bus.ctr_o          = ctr_q;
    assign bus.lr_o           = lr_q;
endmodule

// File: tb/tb_branch_conditional_unit.sv
module tb_branch_conditional_unit;
    localparam int DEPTH = 4;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    always #5 clock_i = ~clock_i;

    branch_conditional_unit_if bus ();

    branch_conditional_unit dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    typedef struct {
        logic [0:27] body;
        logic [63:0] addr;
        logic [63:0] id;
        bit          is64;
    } rec_t;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // ---------------- behavioural model ----------------
    rec_t        mq[$];
    rec_t        m_w;
    bit          m_busy, m_vld, m_taken, m_lrw, m_ovf;
    logic [63:0] m_id, m_tgt, m_ctr, m_lr;

    function automatic void model_resolve(input rec_t r, input logic [63:0] ctr, input logic [31:0] cr,
                                          output bit tk, output logic [63:0] tgt,
                                          output logic [63:0] ctr_n, output logic [63:0] nia);
        bit          decr, ctr_zero, ctr_ok, cond_ok;
        int          d, bi;
        longint      disp;
        logic [63:0] keep;
        decr     = (r.body[2] == 1'b0);
        ctr_n    = decr ? ctr - 64'd1 : ctr;
        ctr_zero = r.is64 ? (ctr_n == 64'd0) : (ctr_n[31:0] == 32'd0);
        ctr_ok   = !decr || ((!ctr_zero) != r.body[3]);
        bi       = int'(r.body[5:9]);
        cond_ok  = r.body[0] || (cr[bi] == r.body[1]);
        d        = int'(r.body[10:23]);
        if (d >= 8192) d = d - 16384;
        disp     = longint'(d) * 4;
        keep     = r.is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        nia      = (r.addr + 64'd4) & keep;
        tk       = ctr_ok && cond_ok;
        tgt      = tk ? ((r.body[26] ? 64'(disp) : r.addr + 64'(disp)) & keep) : nia;
    endfunction

    task automatic model_step();
        bit          acc, tk;
        rec_t        r;
        logic [63:0] tgt, cn, nia;
        if (reset_i) begin
            mq.delete();
            m_busy = 0; m_vld = 0; m_taken = 0; m_lrw = 0; m_ovf = 0;
            m_id = '0; m_tgt = '0; m_ctr = '0; m_lr = '0;
        end else begin
            m_vld = 0;
            acc = bus.enable_i && (bus.functionalUnitType_i == 3'd6) && (bus.opcode_i == 12'd25);
            r.body = bus.instructionBody_i;
            r.addr = bus.instructionAddress_i;
            r.id   = bus.instMajId_i;
            r.is64 = bus.is64Bit_i;
            if (bus.flush_i) begin
                mq.delete();
                m_busy = 0;
            end else begin
                if (m_busy) begin
                    model_resolve(m_w, m_ctr, bus.cr_i, tk, tgt, cn, nia);
                    m_vld   = 1;
                    m_id    = m_w.id;
                    m_taken = tk;
                    m_tgt   = tgt;
                    m_lrw   = m_w.body[27];
                    if (m_w.body[2] == 1'b0) m_ctr = cn;
                    if (m_w.body[27]) m_lr = nia;
                    m_busy  = 0;
                end else if (mq.size() > 0) begin
                    m_w    = mq.pop_front();
                    m_busy = 1;
                end
                if (acc) begin
                    if (mq.size() == DEPTH) m_ovf = 1;
                    else mq.push_back(r);
                end
            end
            if (bus.ctrLoad_i) m_ctr = bus.ctrLoadValue_i;
        end
    endtask

    initial forever begin
        @(posedge clock_i);
        model_step();
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clock_i);
        if (chk_en) begin
            chk("m_valid",    64'(bus.resolveValid_o), 64'(m_vld));
            chk("m_stall",    64'(bus.stall_o),        64'(mq.size() == DEPTH));
            chk("m_overflow", 64'(bus.overflow_o),     64'(m_ovf));
            chk("m_ctr",      bus.ctr_o,               m_ctr);
            chk("m_lr",       bus.lr_o,                m_lr);
            if (m_vld) begin
                chk("m_majid",  bus.resolveMajId_o, m_id);
                chk("m_taken",  64'(bus.taken_o),   64'(m_taken));
                chk("m_target", bus.target_o,       m_tgt);
                chk("m_lrw",    64'(bus.lrWrite_o), 64'(m_lrw));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clock_i);
    endtask

    task automatic load_ctr(input logic [63:0] v);
        bus.ctrLoad_i      = 1'b1;
        bus.ctrLoadValue_i = v;
        tick();
        bus.ctrLoad_i      = 1'b0;
    endtask

    task automatic drive_br(input logic [63:0] id, input logic [63:0] addr, input logic [4:0] bo,
                            input logic [4:0] bi, input logic [13:0] bd, input bit aa, input bit lk,
                            input bit is64);
        bus.enable_i             = 1'b1;
        bus.opcode_i             = 12'd25;
        bus.functionalUnitType_i = 3'd6;
        bus.instMajId_i          = id;
        bus.instructionAddress_i = addr;
        bus.is64Bit_i            = is64;
        bus.instructionBody_i    = {bo, bi, bd, 2'b00, aa, lk};
    endtask

    task automatic send(input logic [63:0] id, input logic [63:0] addr, input logic [4:0] bo,
                        input logic [4:0] bi, input logic [13:0] bd, input bit aa, input bit lk,
                        input bit is64);
        drive_br(id, addr, bo, bi, bd, aa, lk, is64);
        tick();
        bus.enable_i = 1'b0;
    endtask

    task automatic wait_pulse(output int lat);
        lat = 0;
        while (!bus.resolveValid_o && lat < 10) begin
            tick();
            lat++;
        end
        if (!bus.resolveValid_o) chk("pulse_timeout", 64'(bus.resolveValid_o), 64'd1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
    endtask

    initial begin
        int lat;
        bus.enable_i = 0; bus.opcode_i = '0; bus.functionalUnitType_i = '0;
        bus.instructionAddress_i = '0; bus.instMajId_i = '0; bus.is64Bit_i = 1'b1;
        bus.instructionBody_i = '0; bus.cr_i = '0; bus.flush_i = 0;
        bus.ctrLoad_i = 0; bus.ctrLoadValue_i = '0;
        reset_i = 1'b1;
        repeat (2) tick();
        reset_i = 1'b0;
        chk_en  = 1'b1;

        // Reset state after idling.
        repeat (5) tick();
        chk("rst_valid",    64'(bus.resolveValid_o), 64'd0);
        chk("rst_stall",    64'(bus.stall_o),        64'd0);
        chk("rst_overflow", 64'(bus.overflow_o),     64'd0);
        chk("rst_ctr",      bus.ctr_o,               64'd0);
        chk("rst_lr",       bus.lr_o,                64'd0);
        chk("rst_target",   bus.target_o,            64'd0);
        chk("rst_taken",    64'(bus.taken_o),        64'd0);

        // Decrementing branch, CTR 3 -> 2, taken backwards.
        load_ctr(64'd3);
        chk("ld_ctr", bus.ctr_o, 64'd3);
        send(64'd1, 64'h1000, 5'b10000, 5'd0, 14'h3FFF, 1'b0, 1'b0, 1'b1);
        wait_pulse(lat);
        chk("t1_latency", 64'(lat), 64'd2);
        chk("t1_taken",   64'(bus.taken_o), 64'd1);
        chk("t1_target",  bus.target_o, 64'hFFC);
        chk("t1_ctr",     bus.ctr_o, 64'd2);

        // CTR 1 -> 0 makes the same branch fall through.
        load_ctr(64'd1);
        send(64'd2, 64'h1000, 5'b10000, 5'd0, 14'h3FFF, 1'b0, 1'b0, 1'b1);
        wait_pulse(lat);
        chk("t2_taken",  64'(bus.taken_o), 64'd0);
        chk("t2_target", bus.target_o, 64'h1004);
        chk("t2_ctr",    bus.ctr_o, 64'd0);

        // CR-only branch, absolute target with link.
        bus.cr_i = 32'h0000_0004;
        send(64'd3, 64'h2000, 5'b01100, 5'd2, 14'h0010, 1'b1, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("t3_taken",  64'(bus.taken_o), 64'd1);
        chk("t3_target", bus.target_o, 64'h40);
        chk("t3_lr",     bus.lr_o, 64'h2004);
        chk("t3_ctr",    bus.ctr_o, 64'd0);
        bus.cr_i = 32'h0;
        send(64'd4, 64'h3000, 5'b01100, 5'd2, 14'h0010, 1'b1, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("t4_taken",  64'(bus.taken_o), 64'd0);
        chk("t4_target", bus.target_o, 64'h3004);
        chk("t4_lr",     bus.lr_o, 64'h3004);
        chk("t4_lrw",    64'(bus.lrWrite_o), 64'd1);
        tick();

        // Back-to-back burst that ignores stall_o: fills the queue, then overflows.
        for (int i = 0; i < 10; i++) begin
            drive_br(64'(100 + i), 64'h4000 + 64'(16 * i), 5'b10100, 5'd0, 14'(i), 1'b0, 1'b0, 1'b1);
            tick();
            if (i == 6) chk("burst_stall", 64'(bus.stall_o), 64'd1);
        end
        bus.enable_i = 1'b0;
        chk("burst_overflow", 64'(bus.overflow_o), 64'd1);
        repeat (20) tick();
        chk("burst_drained", 64'(bus.stall_o), 64'd0);
        do_reset();
        chk("ovf_cleared", 64'(bus.overflow_o), 64'd0);

        // Flush while one branch is executing and three are queued.
        load_ctr(64'd7);
        bus.cr_i = 32'h0;
        for (int i = 0; i < 6; i++) begin
            drive_br(64'(200 + i), 64'h8000 + 64'(64 * i), 5'b00000, 5'd0, 14'h0008, 1'b0, 1'b0, 1'b1);
            tick();
        end
        bus.enable_i = 1'b0;
        bus.flush_i  = 1'b1;
        tick();
        bus.flush_i  = 1'b0;
        chk("flush_valid", 64'(bus.resolveValid_o), 64'd0);
        chk("flush_ctr",   bus.ctr_o, 64'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("flush_quiet", 64'(bus.resolveValid_o), 64'd0);
        end

        // 32-bit mode address wrapping.
        send(64'd300, 64'h5000, 5'b10100, 5'd0, 14'h0001, 1'b0, 1'b1, 1'b1);
        wait_pulse(lat);
        chk("t6_lr", bus.lr_o, 64'h5004);
        bus.cr_i = 32'h1;
        send(64'd301, 64'hABCD_0000_FFFF_FFFC, 5'b00100, 5'd0, 14'h0004, 1'b0, 1'b1, 1'b0);
        wait_pulse(lat);
        chk("t7_taken",  64'(bus.taken_o), 64'd0);
        chk("t7_target", bus.target_o, 64'h0);
        chk("t7_lr",     bus.lr_o, 64'h0);
        send(64'd302, 64'hFFFF_FFFC, 5'b10100, 5'd0, 14'h0004, 1'b0, 1'b0, 1'b0);
        wait_pulse(lat);
        chk("t8_target", bus.target_o, 64'hC);
        tick();

        // Randomized traffic checked by the model every cycle.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bus.enable_i             = 1'($urandom_range(0, 1));
            bus.opcode_i             = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'd25;
            bus.functionalUnitType_i = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'd6;
            bus.instMajId_i          = 64'(1000 + c);
            bus.instructionAddress_i = {$urandom, $urandom};
            bus.is64Bit_i            = 1'($urandom_range(0, 1));
            bus.instructionBody_i    = {5'($urandom), 5'($urandom), 14'($urandom), 2'b00,
                                        1'($urandom), 1'($urandom)};
            bus.cr_i                 = $urandom;
            bus.flush_i              = ($urandom_range(0, 39) == 0);
            bus.ctrLoad_i            = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 2))
                0:       bus.ctrLoadValue_i = 64'($urandom_range(0, 2));
                1:       bus.ctrLoadValue_i = 64'h1_0000_0000 + 64'($urandom_range(0, 2));
                default: bus.ctrLoadValue_i = {$urandom, $urandom};
            endcase
            reset_i = ($urandom_range(0, 299) == 0);
            tick();
        end
        reset_i = 1'b0;
        bus.enable_i = 1'b0; bus.flush_i = 1'b0; bus.ctrLoad_i = 1'b0;
        repeat (12) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
